// File: rtl/fp_multiplier_seq.sv
// rtl/fp_multiplier_seq.sv - sequential shift-add IEEE-754 single-precision multiplier
// One product bit per enabled clock; stall holds the core until the packed result sits in z.
module fp_multiplier_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    localparam logic [4:0] S_CAPTURE = 5'd24;
    localparam logic [4:0] S_DONE    = 5'd25;

    logic [4:0]  r_s;
    logic [47:0] r_p;
    logic [31:0] r_z;

    logic [4:0]  w_s_next;
    logic [47:0] w_step_in;
    logic [24:0] w_sum;
    logic [47:0] w_step;
    logic        w_sign;
    logic [9:0]  w_e1;
    logic [22:0] w_frac;
    logic [31:0] w_pack;

    // State register: counter, product and result all freeze when ce=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s <= 5'd0;
            r_p <= 48'd0;
            r_z <= 32'd0;
        end else if (ce) begin
            r_s <= w_s_next;
            if (run && (r_s < S_CAPTURE))
                r_p <= w_step;
            if (run && (r_s == S_CAPTURE))
                r_z <= w_pack;
        end
    end

    always_comb begin
        w_s_next = r_s;
        if (!run)
            w_s_next = 5'd0;
        else if (r_s != S_DONE)
            w_s_next = r_s + 5'd1;
    end

    // The first step seeds the low half with y's mantissa so its bits are consumed from the LSB.
    always_comb begin
        w_step_in = (r_s == 5'd0) ? {24'd0, 1'b1, y[22:0]} : r_p;
        w_sum     = {1'b0, w_step_in[47:24]} + (w_step_in[0] ? {2'b01, x[22:0]} : 25'd0);
        w_step    = {w_sum, w_step_in[23:1]};
    end

    always_comb begin
        w_sign = x[31] ^ y[31];
        w_e1   = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127 + {9'd0, r_p[47]};
        w_frac = r_p[47] ? r_p[46:24] : r_p[45:23];
        if ((x[30:23] == 8'd0) || (y[30:23] == 8'd0))
            w_pack = 32'h0;
        else if ($signed(w_e1) >= 10'sd255)
            w_pack = {w_sign, 8'hFF, 23'd0};
        else if ($signed(w_e1) <= 10'sd0)
            w_pack = 32'h0;
        else
            w_pack = {w_sign, w_e1[7:0], w_frac};
    end

    always_comb begin
        stall = run & (r_s != S_DONE);
        z     = r_z;
    end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// tb/tb_fp_multiplier_seq.sv - directed bench with arithmetic reference model and per-cycle compare
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        run = 1'b0;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        stall;
    logic [31:0] z;

    int checks = 0;
    int failures = 0;

    int          m_cnt = 0;
    logic [31:0] m_z = 32'd0;

    fp_multiplier_seq dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .run   (run),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma, mb, prod;
        int          e;
        logic        s;
        s    = a[31] ^ b[31];
        ma   = {24'd0, 1'b1, a[22:0]};
        mb   = {24'd0, 1'b1, b[22:0]};
        prod = ma * mb;
        e    = int'(a[30:23]) + int'(b[30:23]) - 127 + int'(prod[47]);
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return 32'h0;
        return {s, e[7:0], prod[47] ? prod[46:24] : prod[45:23]};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Reference: count of enabled run cycles; result taken on the 25th such edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            m_z   = 32'd0;
        end else if (ce) begin
            if (!run) m_cnt = 0;
            else begin
                if (m_cnt == 24) m_z = model_mul(x, y);
                if (m_cnt < 25) m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        check32("cyc_stall", {31'd0, stall}, {31'd0, run && (m_cnt != 25)});
        check32("cyc_z", z, m_z);
    end

    task automatic run_op(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] exp,
                          input string name, input bit rand_ce);
        bit done;
        done = 1'b0;
        @(posedge clk); #2;
        x = xv; y = yv; run = 1'b1;
        ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else begin
                @(posedge clk); #2;
                if (rand_ce) ce = 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout actual=stall_high required=stall_low", name);
        end
        check32(name, z, exp);
        @(posedge clk); #2;
        ce = 1'b1;
        @(posedge clk); #2;
        run = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic enabled_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        check32("pin_1p5x2", model_mul(32'h3FC00000, 32'h40000000), 32'h40400000);
        check32("pin_1p5sq", model_mul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
        check32("pin_ovf", model_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
        check32("pin_trunc", model_mul(32'h3F800001, 32'h3F800001), 32'h3F800002);

        #1;
        check32("reset_z", z, 32'h0);
        check32("reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        run_op(32'h3FC00000, 32'h40000000, 32'h40400000, "c1_1p5x2", 1'b0);
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "c2_1p5sq", 1'b0);
        run_op(32'hBF800000, 32'h40000000, 32'hC0000000, "c3_neg", 1'b0);
        run_op(32'h00000000, 32'h40490FDB, 32'h00000000, "c3_zero", 1'b0);
        run_op(32'h7F000000, 32'h7F000000, 32'h7F800000, "c4_ovf", 1'b0);
        run_op(32'h40400000, 32'h40A00000, 32'h41700000, "c_3x5", 1'b0);
        run_op(32'h00800000, 32'h00800000, 32'h00000000, "c4_unf", 1'b0);
        run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, "c_trunc", 1'b0);
        run_op(32'h3FC00000, 32'h40000000, 32'h40400000, "c5_ce_rand", 1'b1);

        // Reset in the middle of an operation, then a clean rerun.
        x = 32'h3FC00000; y = 32'h3FC00000; run = 1'b1;
        enabled_cycles(10);
        rst = 1'b1;
        #1;
        check32("c6_rst_z", z, 32'h0);
        check32("c6_rst_stall", {31'd0, stall}, 32'd1);
        run = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "c6_rerun", 1'b0);

        // Abort at S=12 with different operands: z must keep the previous result.
        x = 32'h3FC00000; y = 32'h40000000; run = 1'b1;
        enabled_cycles(12);
        run = 1'b0;
        enabled_cycles(30);
        check32("c6_abort_z", z, 32'h40100000);
        check32("c6_abort_stall", {31'd0, stall}, 32'd0);

        // Hold run high at completion: stall stays low and z stable.
        x = 32'hBF800000; y = 32'h40000000; run = 1'b1;
        enabled_cycles(30);
        check32("hold_z", z, 32'hC0000000);
        check32("hold_stall", {31'd0, stall}, 32'd0);
        run = 1'b0;
        enabled_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
